// File: rtl/soc_clk_rst_seq.sv
// Clock/reset sequencer: divides the board clock into a glitch-free core clock
// and sequences core reset release and fetch enable in core-clock periods.
module soc_clk_rst_seq #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 5,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned FETCH_DLY   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_half_i,
    input  logic             div_load_i,
    input  logic             soft_rst_i,
    input  logic             fetch_en_req_i,
    output logic             usr_clk_o,
    output logic             usr_clk_rise_o,
    output logic             soc_rst_n_o,
    output logic             fetch_en_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    localparam int unsigned MAX_EV = (RST_HOLD > FETCH_DLY) ? RST_HOLD : FETCH_DLY;
    localparam int unsigned CNT_W  = $clog2(MAX_EV + 1);
    localparam logic [DIV_W-1:0] RST_HALF =
        (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(FETCH_DLY - 1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] pending;
    logic             busy;
    logic             usr_clk;
    logic             usr_clk_rise;

    logic             phase_end_c;
    logic             apply_c;
    logic [DIV_W-1:0] load_val_c;

    assign phase_end_c = (cnt == (half - DIV_W'(1)));
    // New divisor takes effect only at the high->low toggle, so both phases stay whole.
    assign apply_c     = phase_end_c && usr_clk && busy;
    assign load_val_c  = (div_half_i == '0) ? DIV_W'(1) : div_half_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            half         <= RST_HALF;
            pending      <= RST_HALF;
            busy         <= 1'b0;
            usr_clk      <= 1'b0;
            usr_clk_rise <= 1'b0;
        end else begin
            if (phase_end_c) begin
                cnt     <= '0;
                usr_clk <= ~usr_clk;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            usr_clk_rise <= phase_end_c && !usr_clk;
            if (apply_c) begin
                half <= pending;
            end
            // A load coinciding with an apply stays pending for the next fall.
            if (div_load_i) begin
                pending <= load_val_c;
                busy    <= 1'b1;
            end else if (apply_c) begin
                busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset / fetch sequencer FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] ev_cnt;
    logic [CNT_W-1:0] ev_cnt_nx;
    logic             soc_rst_n;
    logic             soc_rst_n_nx;
    logic             fetch_en;
    logic             fetch_en_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RST;
            ev_cnt    <= '0;
            soc_rst_n <= 1'b0;
            fetch_en  <= 1'b0;
        end else begin
            state     <= state_nx;
            ev_cnt    <= ev_cnt_nx;
            soc_rst_n <= soc_rst_n_nx;
            fetch_en  <= fetch_en_nx;
        end
    end

    // Soft reset is checked first so it beats a simultaneous count completion.
    always_comb begin
        state_nx  = state;
        ev_cnt_nx = ev_cnt;
        case (state)
            ST_RST: begin
                state_nx  = ST_HOLD;
                ev_cnt_nx = '0;
            end
            ST_HOLD: begin
                if (soft_rst_i) begin
                    ev_cnt_nx = '0;
                end else if (usr_clk_rise) begin
                    if (ev_cnt >= HOLD_LAST) begin
                        state_nx  = ST_WAIT;
                        ev_cnt_nx = '0;
                    end else begin
                        ev_cnt_nx = ev_cnt + CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (soft_rst_i) begin
                    state_nx  = ST_HOLD;
                    ev_cnt_nx = '0;
                end else if (usr_clk_rise) begin
                    if (ev_cnt >= WAIT_LAST) begin
                        state_nx  = ST_RUN;
                        ev_cnt_nx = '0;
                    end else begin
                        ev_cnt_nx = ev_cnt + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (soft_rst_i) begin
                    state_nx  = ST_HOLD;
                    ev_cnt_nx = '0;
                end
            end
            default: begin
                state_nx  = ST_RST;
                ev_cnt_nx = '0;
            end
        endcase
    end

    // Fetch follows the request only once RUN has been entered and is being kept.
    always_comb begin
        soc_rst_n_nx = 1'b0;
        fetch_en_nx  = 1'b0;
        if ((state_nx == ST_WAIT) || (state_nx == ST_RUN)) begin
            soc_rst_n_nx = 1'b1;
        end
        if ((state == ST_RUN) && (state_nx == ST_RUN)) begin
            fetch_en_nx = fetch_en_req_i;
        end
    end

    assign usr_clk_o      = usr_clk;
    assign usr_clk_rise_o = usr_clk_rise;
    assign soc_rst_n_o    = soc_rst_n;
    assign fetch_en_o     = fetch_en;
    assign busy_o         = busy;
    assign state_o        = 2'(state);

endmodule

// File: tb/tb_soc_clk_rst_seq.sv
// Scoreboard bench for soc_clk_rst_seq: a phase-length / rise-count reference model
// pushes per-cycle expectations, a negedge monitor pops and compares them.
module tb_soc_clk_rst_seq;

    localparam int unsigned DIV_W = 8;
    localparam int HOLD = 16;
    localparam int DLY  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] div_half;
    logic             div_load;
    logic             soft_rst;
    logic             fetch_req;
    logic             usr_clk_o;
    logic             usr_clk_rise_o;
    logic             soc_rst_n_o;
    logic             fetch_en_o;
    logic             busy_o;
    logic [1:0]       state_o;

    soc_clk_rst_seq #(
        .DIV_W(DIV_W), .DEFAULT_DIV(5), .RST_HOLD(HOLD), .FETCH_DLY(DLY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .div_half_i     (div_half),
        .div_load_i     (div_load),
        .soft_rst_i     (soft_rst),
        .fetch_en_req_i (fetch_req),
        .usr_clk_o      (usr_clk_o),
        .usr_clk_rise_o (usr_clk_rise_o),
        .soc_rst_n_o    (soc_rst_n_o),
        .fetch_en_o     (fetch_en_o),
        .busy_o         (busy_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       uclk;
        logic       rise;
        logic       rstn;
        logic       fen;
        logic       busy;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endfunction

    // Reference model: clock as whole phases of 'half' cycles, sequence as a count
    // of rise events since (soft) reset start.
    int m_left, m_half, m_pend, m_r;
    bit m_lvl, m_rise, m_busy, m_started, m_fen;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 5; m_half = 5; m_pend = 5; m_r = 0;
            m_lvl = 0; m_rise = 0; m_busy = 0; m_started = 0; m_fen = 0;
            exp_q.delete();
        end else begin
            obs_t e;
            bit   run_before;
            if (!m_started) begin
                m_started = 1; m_r = 0; m_fen = 0;
            end else begin
                run_before = (m_r >= HOLD + DLY);
                if (soft_rst) m_r = 0;
                else if (m_rise && m_r < HOLD + DLY) m_r++;
                m_fen = run_before && !soft_rst && (m_r >= HOLD + DLY) && fetch_req;
            end
            m_left--;
            if (m_left == 0) begin
                if (m_lvl && m_busy) begin
                    m_half = m_pend;
                    m_busy = 0;
                end
                m_lvl  = !m_lvl;
                m_left = m_half;
                m_rise = m_lvl;
            end else begin
                m_rise = 0;
            end
            if (div_load) begin
                m_pend = (div_half == 0) ? 1 : int'(div_half);
                m_busy = 1;
            end
            e.uclk = m_lvl;
            e.rise = m_rise;
            e.rstn = (m_r >= HOLD);
            e.fen  = m_fen;
            e.busy = m_busy;
            e.st   = (m_r < HOLD) ? 2'd1 : (m_r < HOLD + DLY) ? 2'd2 : 2'd3;
            exp_q.push_back(e);
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = {usr_clk_o, usr_clk_rise_o, soc_rst_n_o, fetch_en_o, busy_o, state_o};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_check t=%0t got=%b expected=%b (uclk,rise,rstn,fen,busy,st)",
                         $time, a, e);
            end
        end
    end

    task automatic check_reset_values(string tag);
        chk({tag, "_usr_clk"}, int'(usr_clk_o), 0);
        chk({tag, "_rise"},    int'(usr_clk_rise_o), 0);
        chk({tag, "_rst_n"},   int'(soc_rst_n_o), 0);
        chk({tag, "_fetch"},   int'(fetch_en_o), 0);
        chk({tag, "_busy"},    int'(busy_o), 0);
        chk({tag, "_state"},   int'(state_o), 0);
    endtask

    // Full power-on timing from reset release, with fetch request held high.
    task automatic observe_boot(string tag);
        int rises = 0;
        int last_rise = -100;
        bit seen_rstn = 0;
        bit seen_fen = 0;
        for (int c = 0; c < 600 && !seen_fen; c++) begin
            @(negedge clk);
            if (!seen_rstn && soc_rst_n_o) begin
                seen_rstn = 1;
                chk({tag, "_rstn_rise_count"}, rises, HOLD);
                chk({tag, "_rstn_latency"}, c - last_rise, 1);
            end
            if (!seen_fen && fetch_en_o) begin
                seen_fen = 1;
                chk({tag, "_fetch_rise_count"}, rises, HOLD + DLY);
                chk({tag, "_fetch_latency"}, c - last_rise, 2);
            end
            if (usr_clk_rise_o) begin
                rises++;
                last_rise = c;
            end
        end
        if (!seen_fen) chk({tag, "_boot_timeout"}, 0, 1);
    endtask

    task automatic wait_rise(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!usr_clk_rise_o && n < 100);
        if (n >= 100) chk({tag, "_rise_timeout"}, 0, 1);
    endtask

    task automatic load_div(int unsigned v);
        div_half = DIV_W'(v);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic pulse_soft();
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; div_half = '0; div_load = 1'b0; soft_rst = 1'b0; fetch_req = 1'b1;
        #1;
        check_reset_values("por");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // T1: boot timing at the default divisor
        observe_boot("t1");
        repeat (30) @(negedge clk);

        // T2: reprogram during the high phase
        wait_rise("t2");
        load_div(2);
        chk("t2_busy_set", int'(busy_o), 1);
        n = 0;
        while (busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t2_busy_cleared", int'(busy_o), 0);
        repeat (20) @(negedge clk);

        // T3: zero divisor acts as 1
        load_div(0);
        repeat (30) @(negedge clk);
        load_div(5);
        repeat (40) @(negedge clk);

        // T4: soft reset from RUN, then again in HOLD
        pulse_soft();
        chk("t4_state_hold", int'(state_o), 1);
        chk("t4_rst_n_low", int'(soc_rst_n_o), 0);
        chk("t4_fetch_low", int'(fetch_en_o), 0);
        repeat (60) @(negedge clk);
        pulse_soft();
        chk("t4_hold_restart_state", int'(state_o), 1);

        // T6 and random mix: fetch request, loads and soft resets
        for (int c = 0; c < 6000; c++) begin
            fetch_req = ($urandom_range(0, 3) == 0) ? ~fetch_req : fetch_req;
            div_half  = DIV_W'($urandom_range(0, 9));
            div_load  = ($urandom_range(0, 39) == 0);
            soft_rst  = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        div_load = 1'b0; soft_rst = 1'b0; fetch_req = 1'b1;

        // T5: asynchronous reset in WAIT
        load_div(3);
        pulse_soft();
        n = 0;
        while (state_o != 2'd2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_wait", int'(state_o), 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_values("t5");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        observe_boot("t5_reboot");
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
